// File: rtl/wam_hit.sv
// Whack-a-mole hit detector: synchronizes player buttons, classifies presses as
// hits or misses against the mole mask, and keeps BCD score/miss counters.
//
// state | meaning
// IDLE  | game paused or not yet started; presses discarded
// PLAY  | presses accepted and scored
// OVER  | miss limit reached; counters frozen until clr
module wam_hit #(
  parameter logic [7:0] MAX_MISS = 8'h05,
  parameter int         WIDTH    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] holes,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] hit,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [7:0]       score,
  output logic [7:0]       misses,
  output logic             over
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WIDTH-1:0] arm_q, arm_d;
  logic [1:0]       vld_q, vld_d;
  logic [WIDTH-1:0] lock_q, lock_d;
  logic [7:0]       score_q, score_d, misses_q, misses_d;
  logic             hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;

  logic [WIDTH-1:0] press, accepted, hit_vec, miss_vec;
  logic             hit_evt, miss_evt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)           r = v;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // A button only arms once the synchronizer has refilled after clr and shows it
  // released, so a button held through clr does not look like a fresh edge.
  always_comb begin
    s1_d  = btn;
    s2_d  = s1_q;
    s3_d  = s2_q;
    vld_d = {vld_q[0], 1'b1};
    arm_d = arm_q | ({WIDTH{vld_q[1]}} & ~s2_q);
  end

  always_comb begin
    press    = s2_q & ~s3_q & arm_q;
    accepted = press & {WIDTH{(state_q == PLAY) && en}};
    hit_vec  = accepted & holes & ~lock_q;
    miss_vec = accepted & ~hit_vec;
    hit_evt  = |hit_vec;
    miss_evt = |miss_vec;
  end

  always_comb begin
    state_d      = state_q;
    lock_d       = (lock_q | hit_vec) & holes;
    score_d      = hit_evt  ? bcd_inc(score_q)  : score_q;
    misses_d     = miss_evt ? bcd_inc(misses_q) : misses_q;
    hit_pulse_d  = hit_evt;
    miss_pulse_d = miss_evt;
    case (state_q)
      IDLE: if (en) state_d = PLAY;
      PLAY: begin
        if (!en)                                  state_d = IDLE;
        else if (miss_evt && misses_d == MAX_MISS) state_d = OVER;
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      arm_q        <= '0;
      vld_q        <= '0;
      lock_q       <= '0;
      score_q      <= 8'h00;
      misses_q     <= 8'h00;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      arm_q        <= arm_d;
      vld_q        <= vld_d;
      lock_q       <= lock_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign hit        = lock_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign over       = (state_q == OVER);

endmodule

// File: tb/tb_wam_hit.sv
// Directed bench for wam_hit with hand-computed expectations.
module tb_wam_hit;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [7:0] holes = '0;
  logic [7:0] btn = '0;
  logic [7:0] hit;
  logic       hit_pulse, miss_pulse, over;
  logic [7:0] score, misses;

  int checks = 0;
  int failures = 0;
  int hp_cnt, mp_cnt;

  wam_hit dut (
    .clk(clk), .clr(clr), .en(en), .holes(holes), .btn(btn),
    .hit(hit), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .misses(misses), .over(over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hp_cnt += int'(hit_pulse);
    mp_cnt += int'(miss_pulse);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // press held 3 cycles, released 3 cycles; pulses tallied meanwhile
  task automatic press(input logic [7:0] mask);
    hp_cnt = 0;
    mp_cnt = 0;
    btn = mask;
    repeat (3) tick();
    btn = '0;
    repeat (3) tick();
  endtask

  task automatic score_hit();
    holes = 8'h01;
    press(8'h01);
    holes = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("rst_score", score, 8'h00);
    chk("rst_misses", misses, 8'h00);
    chk("rst_hit", hit, 8'h00);
    chk("rst_over", over, 1'b0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 2'b00);
    repeat (4) @(negedge clk);

    // single hit with latency and lock release
    en = 1'b1;
    holes = 8'h04;
    @(negedge clk);
    btn = 8'h04;
    @(negedge clk);
    @(negedge clk);
    chk("lat_k1_score", score, 8'h00);
    chk("lat_k1_pulse", hit_pulse, 1'b0);
    @(negedge clk);
    chk("lat_k2_hit", hit, 8'h04);
    chk("lat_k2_pulse", hit_pulse, 1'b1);
    chk("lat_k2_score", score, 8'h01);
    btn = '0;
    @(negedge clk);
    chk("pulse_one_cycle", hit_pulse, 1'b0);
    holes = 8'h00;
    @(negedge clk);
    chk("lock_clear", hit, 8'h00);

    // double press on a locked hole
    do_clr();
    holes = 8'h04;
    press(8'h04);
    press(8'h04);
    chk("locked_score", score, 8'h01);
    chk("locked_misses", misses, 8'h01);
    chk("locked_hit", hit, 8'h04);

    // simultaneous hits count once
    do_clr();
    holes = 8'h0F;
    press(8'h0F);
    chk("multi_score", score, 8'h01);
    chk("multi_hit", hit, 8'h0F);
    chk("multi_misses", misses, 8'h00);
    chk("multi_pulses", hp_cnt, 1);
    // hit and miss together
    holes = 8'h10;
    press(8'h30);
    chk("mix_score", score, 8'h02);
    chk("mix_misses", misses, 8'h01);
    chk("mix_pulses", {hp_cnt[3:0], mp_cnt[3:0]}, 8'h11);

    // BCD carry and saturation
    do_clr();
    holes = 8'h00;
    repeat (9) score_hit();
    chk("bcd_09", score, 8'h09);
    score_hit();
    chk("bcd_10", score, 8'h10);
    repeat (89) score_hit();
    chk("bcd_99", score, 8'h99);
    score_hit();
    chk("sat_99", score, 8'h99);
    chk("sat_pulse", hp_cnt, 1);

    // miss limit ends the game
    do_clr();
    holes = 8'h00;
    repeat (4) press(8'h02);
    chk("m4_misses", misses, 8'h04);
    chk("m4_over", over, 1'b0);
    press(8'h02);
    chk("m5_misses", misses, 8'h05);
    chk("m5_over", over, 1'b1);
    holes = 8'h08;
    press(8'h0A);
    chk("over_frozen", {score, misses}, 16'h0005);
    chk("over_no_pulse", hp_cnt + mp_cnt, 0);
    holes = 8'h00;
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_ignores_en", over, 1'b1);
    en = 1'b1;
    do_clr();
    chk("clr_all", {score, misses, hit, 7'd0, over}, 32'h0);

    // presses while disabled are dropped
    holes = 8'h04;
    en = 1'b0;
    press(8'h04);
    chk("en0_counts", {score, misses}, 16'h0000);
    chk("en0_pulses", hp_cnt + mp_cnt, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    press(8'h04);
    chk("en1_after", score, 8'h01);

    // button held through clr
    btn = 8'h04;
    holes = 8'h04;
    repeat (3) @(negedge clk);
    do_clr();
    hp_cnt = 0;
    mp_cnt = 0;
    repeat (6) tick();
    chk("held_no_press", {score, misses, hit}, 24'h0);
    chk("held_no_pulse", hp_cnt + mp_cnt, 0);
    btn = 8'h00;
    repeat (3) @(negedge clk);
    press(8'h04);
    chk("repress_score", score, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end
endmodule
